// File: rtl/sample_mixer.sv
// ============================================================================
// sample_mixer: sums offset-binary voice samples once per sample period,
// attenuates, re-biases and saturates to one unsigned 8-bit PWM sample.
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_mixer #(
    parameter int NUM_VOICES = 4,
    parameter int CLK_DIV    = 256
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [NUM_VOICES*8-1:0] voice_in,
    input  logic [NUM_VOICES-1:0]   voice_en,
    input  logic [1:0]              master_shift,
    output logic [7:0]              sample_o,
    output logic                    sample_tick_o,
    output logic                    clip_o
);

    localparam int ACC_W = 10 + $clog2(NUM_VOICES);
    localparam int RES_W = ACC_W + 1;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_SCALE = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_tick;
    logic                      w_wrap;
    logic [NUM_VOICES*8-1:0]   r_voice;
    logic [NUM_VOICES-1:0]     r_en;
    logic [1:0]                r_shift;
    logic [IDX_W-1:0]          r_idx;
    logic signed [ACC_W-1:0]   r_acc;
    logic [RES_W-1:0]          r_res;
    logic [7:0]                r_sample;
    logic                      r_clip;
    logic signed [8:0]         w_term9;
    logic signed [ACC_W-1:0]   w_term;
    logic signed [ACC_W-1:0]   w_shifted;
    logic [RES_W-1:0]          w_scaled;

    assign w_wrap = (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_tick <= w_wrap;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_wrap) w_state_nxt = S_ACCUM;
            S_ACCUM: if (r_idx == c_idx_last) w_state_nxt = S_SCALE;
            S_SCALE: w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // The snapshot is shifted down one voice per cycle, so voice idx is always in the low byte.
    assign w_term9   = $signed({1'b0, r_voice[7:0]}) - 9'sd128;
    assign w_term    = r_en[0] ? {{(ACC_W-9){w_term9[8]}}, w_term9} : '0;
    assign w_shifted = r_acc >>> r_shift;
    assign w_scaled  = {w_shifted[ACC_W-1], w_shifted} + RES_W'(128);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_voice  <= '0;
            r_en     <= '0;
            r_shift  <= '0;
            r_idx    <= '0;
            r_acc    <= '0;
            r_res    <= '0;
            r_sample <= 8'd128;
            r_clip   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wrap) begin
                        r_voice <= voice_in;
                        r_en    <= voice_en;
                        r_shift <= master_shift;
                        r_acc   <= '0;
                        r_idx   <= '0;
                    end
                end
                S_ACCUM: begin
                    r_acc   <= r_acc + w_term;
                    r_voice <= r_voice >> 8;
                    r_en    <= r_en >> 1;
                    r_idx   <= r_idx + IDX_W'(1);
                end
                S_SCALE: begin
                    r_res <= w_scaled;
                end
                S_LOAD: begin
                    if (r_res[RES_W-1]) begin
                        r_sample <= 8'd0;
                        r_clip   <= 1'b1;
                    end else if (|r_res[RES_W-2:8]) begin
                        r_sample <= 8'd255;
                        r_clip   <= 1'b1;
                    end else begin
                        r_sample <= r_res[7:0];
                        r_clip   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sample_o      = r_sample;
    assign clip_o        = r_clip;
    assign sample_tick_o = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_sample_mixer.sv
// ============================================================================
// tb_sample_mixer: directed self-checking bench for sample_mixer (4 voices, 256 clk period).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sample_mixer;

    logic        clk;
    logic        n_rst;
    logic [31:0] voice_in;
    logic [3:0]  voice_en;
    logic [1:0]  master_shift;
    logic [7:0]  sample_o;
    logic        sample_tick_o;
    logic        clip_o;

    int total = 0;
    int bad   = 0;
    int g_cyc = 0;
    int t0, t1;

    sample_mixer #(
        .NUM_VOICES (4),
        .CLK_DIV    (256)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .voice_in      (voice_in),
        .voice_en      (voice_en),
        .master_shift  (master_shift),
        .sample_o      (sample_o),
        .sample_tick_o (sample_tick_o),
        .clip_o        (clip_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) g_cyc <= g_cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for the tick, returning the cycle count at which it was seen.
    task automatic wait_tick(output int at);
        at = -1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (sample_tick_o === 1'b1) begin
                at = g_cyc;
                break;
            end
        end
        if (at < 0) chk("tick_timeout", 32'd0, 32'd1);
    endtask

    // Checks output held through latency-1 cycles, then the new value at latency 6.
    task automatic run_period(input string tag, input logic [7:0] old_s,
                              input logic [7:0] exp_s, input logic exp_c);
        int at;
        wait_tick(at);
        repeat (5) @(negedge clk);
        chk({tag, "_hold"}, {24'd0, sample_o}, {24'd0, old_s});
        @(negedge clk);
        chk({tag, "_sample"}, {24'd0, sample_o}, {24'd0, exp_s});
        chk({tag, "_clip"}, {31'd0, clip_o}, {31'd0, exp_c});
    endtask

    initial begin
        n_rst        = 1'b0;
        voice_in     = {4{8'd128}};
        voice_en     = 4'hF;
        master_shift = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_sample", {24'd0, sample_o}, 32'd128);
        chk("rst_tick", {31'd0, sample_tick_o}, 32'd0);
        chk("rst_clip", {31'd0, clip_o}, 32'd0);

        // T1: first tick latency and silent mix
        n_rst = 1'b1;
        t0 = g_cyc;
        wait_tick(t1);
        chk("first_tick_delay", t1 - t0, 32'd256);
        @(negedge clk);
        chk("tick_one_cycle", {31'd0, sample_tick_o}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t1_sample", {24'd0, sample_o}, 32'd128);
        chk("t1_clip", {31'd0, clip_o}, 32'd0);

        // T2: single voice
        voice_in = {8'd0, 8'd0, 8'd0, 8'd200};
        voice_en = 4'b0001;
        run_period("t2", 8'd128, 8'd200, 1'b0);

        // T3: all loud, then attenuated to exactly full scale
        voice_in = {4{8'd255}};
        voice_en = 4'hF;
        run_period("t3a", 8'd200, 8'd255, 1'b1);
        master_shift = 2'd2;
        run_period("t3b", 8'd255, 8'd255, 1'b0);

        // T4: all minimum, then attenuated to exactly zero
        voice_in     = {4{8'd0}};
        master_shift = 2'd0;
        run_period("t4a", 8'd255, 8'd0, 1'b1);
        master_shift = 2'd2;
        run_period("t4b", 8'd0, 8'd0, 1'b0);

        // Arithmetic shift rounds toward -inf: -1 >>> 1 = -1 -> 127
        voice_in     = {8'd0, 8'd0, 8'd0, 8'd127};
        voice_en     = 4'b0001;
        master_shift = 2'd1;
        run_period("round", 8'd0, 8'd127, 1'b0);

        // All voices disabled gives silence
        voice_in     = {4{8'd255}};
        voice_en     = 4'h0;
        master_shift = 2'd0;
        run_period("all_off", 8'd127, 8'd128, 1'b0);

        // Mixed voices: (10-128)+(100-128)+(130-128) = -144, >>>1 = -72 -> 56
        voice_in     = {8'd77, 8'd130, 8'd100, 8'd10};
        voice_en     = 4'b0111;
        master_shift = 2'd1;
        run_period("mix", 8'd128, 8'd56, 1'b0);

        // T5: input change after snapshot only affects the next period
        voice_in     = {8'd0, 8'd0, 8'd0, 8'd200};
        voice_en     = 4'b0001;
        master_shift = 2'd0;
        wait_tick(t0);
        repeat (2) @(negedge clk);
        voice_in = {8'd0, 8'd0, 8'd0, 8'd50};
        repeat (4) @(negedge clk);
        chk("t5_this_period", {24'd0, sample_o}, 32'd200);
        wait_tick(t1);
        chk("t5_tick_period", t1 - t0, 32'd256);
        repeat (6) @(negedge clk);
        chk("t5_next_period", {24'd0, sample_o}, 32'd50);

        // T6: reset during ACCUM
        voice_in = {4{8'd255}};
        voice_en = 4'hF;
        wait_tick(t0);
        repeat (2) @(negedge clk);
        n_rst = 1'b0;
        #1;
        chk("t6_rst_sample", {24'd0, sample_o}, 32'd128);
        chk("t6_rst_clip", {31'd0, clip_o}, 32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        t0 = g_cyc;
        wait_tick(t1);
        chk("t6_tick_after_rst", t1 - t0, 32'd256);
        repeat (6) @(negedge clk);
        chk("t6_sample", {24'd0, sample_o}, 32'd255);
        chk("t6_clip", {31'd0, clip_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
